// File: rtl/rx_acq_gate.sv
// rx_acq_gate: trigger-driven acquisition gate; after a range delay, holds en for cfg_len samples while forwarding adc_in.
module rx_acq_gate #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              ovr_clr,
  input  logic [DATA_W-1:0] adc_in,
  output logic              en,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DONE} state_t;
  state_t           r_state;
  logic             r_trig_q;
  logic [CNT_W-1:0] r_cnt, r_d, r_l;
  logic             w_evt;
  assign w_evt = trig & ~r_trig_q;
  assign busy  = r_state != IDLE;
  // r_cnt starts at 1 and is compared for equality, so D and L up to all-ones never wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_trig_q <= 1'b0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_l      <= '0;
      en       <= 1'b0;
      dout     <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      r_trig_q <= trig;
      done     <= 1'b0;
      overrun  <= (w_evt && busy) ? 1'b1 : ovr_clr ? 1'b0 : overrun;
      case (r_state)
        IDLE:
          if (w_evt && arm && cfg_len != '0) begin
            r_d   <= cfg_delay;
            r_l   <= cfg_len;
            r_cnt <= CNT_W'(1);
            if (cfg_delay == '0) begin
              r_state <= CAPTURE;
              en      <= 1'b1;
              dout    <= adc_in;
            end else begin
              r_state <= DELAY;
            end
          end
        DELAY:
          if (r_cnt == r_d) begin
            r_state <= CAPTURE;
            en      <= 1'b1;
            dout    <= adc_in;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        CAPTURE:
          if (r_cnt == r_l) begin
            r_state <= DONE;
            en      <= 1'b0;
            done    <= 1'b1;
          end else begin
            dout  <= adc_in;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        DONE: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_acq_gate.sv
// tb_rx_acq_gate: vector table for the basic window and null triggers, plus windowed sequences with a small timing model.
module tb_rx_acq_gate;
  logic        clk = 1'b0;
  logic        rst = 1'b1, arm = 1'b0, trig = 1'b0, ovr_clr = 1'b0;
  logic [15:0] cfg_delay = '0, cfg_len = '0;
  logic [31:0] adc_in = '0;
  logic        en, busy, done, overrun;
  logic [31:0] dout;
  int          nvec = 0, nmis = 0;
  logic        g_ov = 1'b0, tprev = 1'b0;
  logic [31:0] last = '0, a;

  rx_acq_gate #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .cfg_delay(cfg_delay), .cfg_len(cfg_len),
    .ovr_clr(ovr_clr), .adc_in(adc_in), .en(en), .dout(dout), .busy(busy), .done(done), .overrun(overrun)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic        rst, arm, trig;
    logic [15:0] d, l;
    logic        clr;
    logic [31:0] adc;
    logic        en;
    logic [31:0] dout;
    logic        busy, done, ovr;
  } vec_t;
  vec_t tv[14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic e_en, input logic [31:0] e_dout,
                     input logic e_busy, input logic e_done, input logic e_ovr);
    nvec++;
    if ({en, dout, busy, done, overrun} !== {e_en, e_dout, e_busy, e_done, e_ovr}) begin
      nmis++;
      $display("FAIL %s: got en=%b dout=%h busy=%b done=%b ovr=%b, want en=%b dout=%h busy=%b done=%b ovr=%b",
               nm, en, dout, busy, done, overrun, e_en, e_dout, e_busy, e_done, e_ovr);
    end
  endtask

  // trigger at m=0; rt = retrigger index, cl = ovr_clr index, hold = trig held for m<hold, nl = cfg_len rewrite at m=3
  task automatic win(input string tag, input int d, input int l, input int rt, input int cl,
                     input int hold, input int nl, input bit arm_keep);
    int  n;
    logic ev, bsy, w;
    n = d + l + 2;
    if (hold + 1 > n) n = hold + 1;
    if (cl + 1 > n) n = cl + 1;
    for (int m = 0; m < n; m++) begin
      trig    = (m == 0) || (m < hold) || (m == rt);
      ovr_clr = (m == cl);
      arm     = (m == 0) || arm_keep;
      if (m == 0) begin
        cfg_delay = d[15:0];
        cfg_len   = l[15:0];
      end
      if (m == 3 && nl >= 0) cfg_len = nl[15:0];
      adc_in = $urandom;
      ev  = trig && !tprev;
      bsy = (m >= 1) && (m <= d + l + 1);
      if (ev && bsy) g_ov = 1'b1;
      else if (ovr_clr) g_ov = 1'b0;
      tprev = trig;
      w = (m >= d) && (m <= d + l - 1);
      if (w) last = adc_in;
      tick;
      chk($sformatf("%s m=%0d", tag, m), w, last, m <= d + l, m == d + l, g_ov);
    end
    trig    = 1'b0;
    ovr_clr = 1'b0;
    tprev   = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 32'd0,  1'b0, 32'd0,  1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 32'd19, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd4, 1'b0, 32'd20, 1'b1, 32'd20, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd4, 1'b0, 32'd21, 1'b1, 32'd21, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 32'd22, 1'b1, 32'd22, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 32'd23, 1'b1, 32'd23, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 32'd24, 1'b0, 32'd23, 1'b1, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd4, 1'b0, 32'd25, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0, 32'd26, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd27, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b1, 16'd0, 16'd5, 1'b0, 32'd28, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd5, 1'b0, 32'd29, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 1'b1, 32'd30, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 32'd31, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      rst = tv[i].rst; arm = tv[i].arm; trig = tv[i].trig; cfg_delay = tv[i].d;
      cfg_len = tv[i].l; ovr_clr = tv[i].clr; adc_in = tv[i].adc;
      tick;
      chk($sformatf("vec%0d", i), tv[i].en, tv[i].dout, tv[i].busy, tv[i].done, tv[i].ovr);
    end
    last = 32'd23;
    win("d10l12", 10, 12, -1, -1, 0, -1, 1'b1);
    win("retrig", 3, 20, 11, -1, 0, -1, 1'b1);
    win("clr", 3, 20, -1, 26, 0, -1, 1'b1);
    win("clrset", 3, 20, 15, 15, 0, -1, 1'b1);
    win("armdrop", 2, 6, -1, -1, 0, -1, 1'b0);
    cfg_delay = 16'd0; cfg_len = 16'd10; arm = 1'b1; trig = 1'b1;
    adc_in = $urandom; a = adc_in; tick; chk("rstw0", 1'b1, a, 1'b1, 1'b0, g_ov);
    trig = 1'b0;
    adc_in = $urandom; a = adc_in; tick; chk("rstw1", 1'b1, a, 1'b1, 1'b0, g_ov);
    adc_in = $urandom; a = adc_in; tick; chk("rstw2", 1'b1, a, 1'b1, 1'b0, g_ov);
    rst = 1'b1; adc_in = $urandom; tick;
    g_ov = 1'b0; last = '0; tprev = 1'b0;
    chk("rst_mid", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; tick; chk("rst_rel0", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick; chk("rst_rel1", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    win("fresh", 0, 10, -1, -1, 0, -1, 1'b1);
    win("cfgchg", 2, 8, -1, -1, 0, 3, 1'b1);
    win("len3", 1, 3, -1, -1, 0, -1, 1'b1);
    win("hold", 2, 5, -1, -1, 50, -1, 1'b1);
    win("maxd", 65535, 3, -1, -1, 0, -1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/rx_acq_gate.md
Name: rx_acq_gate

Overview:
- Acquisition gate directly upstream of bram_ctrl in the HFSWR receive chain.
- On each transmit-pulse trigger, waits a programmable range delay, then holds `en` high for exactly a programmable number of ADC samples while forwarding those samples on `dout`.
- bram_ctrl consumes `en` and `dout` to store the echo window into BRAM.
- ADC samples arrive once per clock (122.88 MHz, period 8.138 ns), so all delays and lengths are counted in clock cycles.

Parameters:
- DATA_W, 32, width of adc_in and dout.
- CNT_W, 16, width of cfg_delay, cfg_len and the internal counters.

Ports:
- clk  input  1  system clock, ADC sample rate.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  level; triggers are accepted only while high.
- trig  input  1  transmit-pulse marker, synchronous to clk; a rising edge starts a capture.
- cfg_delay  input  CNT_W  range delay in samples, from trigger edge to first captured sample.
- cfg_len  input  CNT_W  window length in samples; 0 disables capture.
- ovr_clr  input  1  clears the overrun flag.
- adc_in  input  DATA_W  raw ADC sample, valid every cycle.
- en  output  1  capture window to bram_ctrl; high for exactly cfg_len consecutive cycles.
- dout  output  DATA_W  registered sample to bram_ctrl.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the window closes.
- overrun  output  1  sticky; a trigger edge arrived while busy.

Behaviour:
- Reset (synchronous): state=IDLE; en=0, dout=0, busy=0, done=0, overrun=0; counters=0; trig edge register=0. Reset asserted mid-capture drops en in the cycle after the reset edge; the partial window is abandoned with no done pulse.
- Edge detect: trig_q registers trig every cycle. A trigger event at edge T means trig=1 and trig_q=0 at T.
- IDLE:
  - On a trigger event with arm=1 and cfg_len!=0: latch cfg_delay and cfg_len.
  - If delay=0, go to CAPTURE; otherwise go to DELAY.
  - A trigger event with arm=0 or cfg_len=0 is ignored and does not set overrun.
- DELAY: counter counts latched delay cycles, then enters CAPTURE. en first high in cycle T+1+D.
- CAPTURE:
  - en=1 for exactly L cycles.
  - dout is registered every cycle. In the k-th en cycle (k=0..L-1), dout = adc_in sampled at edge T+D+k.
  - After the L-th en cycle, go to DONE.
- DONE: done=1 for one cycle; en=0; return to IDLE. A new trigger is accepted in IDLE the cycle after DONE. Minimum trigger spacing is D+L+2 cycles.
- Overrun:
  - A trigger event while busy=1 (DELAY, CAPTURE or DONE), regardless of arm, sets overrun and is otherwise ignored. The capture in progress is unaffected.
  - ovr_clr=1 clears overrun.
  - Simultaneous ovr_clr and a new overrun event: overrun ends up 1 (set wins).
- Configuration changes: cfg_delay and cfg_len are sampled only at trigger acceptance. Changes while busy affect only the next capture.
- arm deasserted while busy: the current capture completes normally.
- Maximum values: D=2^CNT_W-1 and L=2^CNT_W-1 must work with no counter wrap. The counters are CNT_W wide and compare against latched values; there is no +1 overflow.
- trig held high continuously produces a single trigger event.
- dout holds its last value outside the window. Downstream qualifies dout with en only.

Test Plan:
- Reset, D=0, L=4, adc_in=cycle counter, trig edge at cycle 20 → en high in cycles 21–24, dout=20,21,22,23; done pulse in cycle 25; busy high in cycles 21–25.
- D=10, L=12, trig edge at cycle 5 → en high in cycles 16–27 exactly (12 cycles), dout=15..26; done in cycle 28; no overrun.
- Second trig edge during CAPTURE (D=3, L=20, retrigger 8 cycles into the window) → en stays continuous for 20 cycles, overrun=1 afterwards. Then ovr_clr pulse → overrun=0. Then ovr_clr and a retrigger in the same cycle → overrun=1.
- cfg_len=0 with a trig edge → no en, no busy, no done, overrun stays 0. arm=0 with a trig edge and L=5 → same null response.
- rst asserted in the 3rd en cycle of an L=10 window → en=0, busy=0, state IDLE in the next cycle, no done pulse. A trig edge 2 cycles after reset release starts a full fresh window.
- cfg_len changed from 8 to 3 mid-capture → current window lasts 8 cycles, and the next triggered window lasts 3 cycles. trig held high for 50 cycles → exactly one window.
